// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared state encoding and default width for the bit-serial adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_bit.sv
//------------------------------------------------------------------------------
// Module   : fa_bit
// Brief    : Combinational full-adder slice: two half-adder cells plus an OR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_ha0_s;
  logic w_ha0_c;
  logic w_ha1_c;

  // First half-adder combines the operands, second folds in the carry.
  assign w_ha0_s = a ^ b;
  assign w_ha0_c = a & b;
  assign s       = w_ha0_s ^ cin;
  assign w_ha1_c = w_ha0_s & cin;
  assign cout    = w_ha0_c | w_ha1_c;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : LSB-first bit-serial adder with start/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int                c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_ra;
  logic [WIDTH-1:0]   r_rb;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_next;
  logic               r_c;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_s;
  logic               w_cout;
  logic               w_last;

  fa_bit u_fa_bit (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  // New sum bit enters at the MSB so the LSB-first result lands in place.
  if (WIDTH == 1) begin : g_acc_single
    assign w_acc_next = w_s;
  end else begin : g_acc_multi
    assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ra  <= A;
            r_rb  <= B;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_c   <= w_cout;
          r_acc <= w_acc_next;
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_cnt <= r_cnt + c_cnt_w'(1);
          // Results publish only on the final bit, so they hold during SHIFT.
          if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       a1, b1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic       sum1;

  logic       sel;
  logic       m_busy, m_done, m_cout;
  logic [7:0] m_sum;

  int         checks;
  int         failures;
  logic [7:0] prev_sum  [0:1];
  logic       prev_cout [0:1];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .busy  (busy1),
    .done  (done1),
    .Sum   (sum1),
    .Cout  (cout1)
  );

  assign m_busy = sel ? busy1 : busy8;
  assign m_done = sel ? done1 : done8;
  assign m_cout = sel ? cout1 : cout8;
  assign m_sum  = sel ? {7'b0, sum1} : sum8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {Cout,Sum} is the plain (w+1)-bit sum of the masked operands.
  task automatic run(input bit w1, input logic [7:0] a, input logic [7:0] b, input bit hold);
    int         w, lat, busy_cnt;
    bit         seen, unstable;
    logic [7:0] mask;
    logic [8:0] full;
    logic [7:0] exp_sum;
    logic       exp_cout;
    w        = w1 ? 1 : 8;
    mask     = w1 ? 8'h01 : 8'hFF;
    full     = {1'b0, a & mask} + {1'b0, b & mask};
    exp_sum  = full[7:0] & mask;
    exp_cout = w1 ? full[1] : full[8];
    sel      = w1;
    if (w1) begin
      a1 = a[0]; b1 = b[0]; start1 = 1'b1;
    end else begin
      a8 = a; b8 = b; start8 = 1'b1;
    end
    step();
    if (!hold) begin
      start1 = 1'b0; start8 = 1'b0;
    end
    lat = 0; busy_cnt = 0; seen = 1'b0; unstable = 1'b0;
    for (int k = 1; k <= w + 4; k++) begin
      if (m_busy) busy_cnt++;
      if (m_done) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
      if (m_sum !== prev_sum[w1] || m_cout !== prev_cout[w1]) unstable = 1'b1;
      step();
    end
    start1 = 1'b0; start8 = 1'b0;
    check("done_seen",   32'(seen),     32'd1);
    check("latency",     32'(lat),      32'(w + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(w + 1));
    check("hold_stable", 32'(unstable), 32'd0);
    check("sum",         32'(m_sum),    32'(exp_sum));
    check("cout",        32'(m_cout),   32'(exp_cout));
    prev_sum[w1]  = exp_sum;
    prev_cout[w1] = exp_cout;
  endtask

  initial begin
    bit extra_done;
    checks = 0; failures = 0;
    rst = 1'b1; sel = 1'b0;
    start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    prev_sum[0] = '0; prev_sum[1] = '0;
    prev_cout[0] = 1'b0; prev_cout[1] = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_sum1",  32'(sum1),  32'd0);

    run(1'b0, 8'h00, 8'h00, 1'b0); step();
    run(1'b0, 8'hFF, 8'h01, 1'b0); step();

    // Start held high while busy must not queue a second operation.
    run(1'b0, 8'hA5, 8'h5A, 1'b1); step();
    check("no_extra_done", 32'(done8), 32'd0);
    check("idle_not_busy", 32'(busy8), 32'd0);
    run(1'b0, 8'h80, 8'h80, 1'b0); step();

    // Abort in the fourth SHIFT cycle.
    sel = 1'b0; a8 = 8'h3C; b8 = 8'h0F; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum",  32'(sum8),  32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    extra_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done8) extra_done = 1'b1;
      step();
    end
    check("abort_no_done", 32'(extra_done), 32'd0);
    prev_sum[0] = '0; prev_cout[0] = 1'b0;
    prev_sum[1] = '0; prev_cout[1] = 1'b0;
    run(1'b0, 8'h01, 8'h02, 1'b0); step();

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      run(1'b1, {7'b0, ab[1]}, {7'b0, ab[0]}, 1'b0); step();
    end

    for (int i = 0; i < 200; i++) begin
      run(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
